// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer and its synchronizers.
package pll_rst_pkg;

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 1000000;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_MAX_RETRIES    = 3;

   localparam logic [3:0] RETRY_SAT = 4'd15;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous reset to a parameterized value.
module sync_2ff #(
   parameter int   WIDTH   = 1,
   parameter logic RST_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= {WIDTH{RST_VAL}};
         q    <= {WIDTH{RST_VAL}};
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable lock, then releases system reset;
// retries on lock timeout or lock loss and raises a sticky fault after too many.
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       soft_rst_req,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_count
);

   localparam int MAXC = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          lk_s;
   logic [3:0]    retry_inc;

   sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk_s)
   );

   assign retry_inc = (retry_count == RETRY_SAT) ? RETRY_SAT : retry_count + 4'd1;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= RESET_PLL;
         cnt         <= '0;
         fault       <= 1'b0;
         retry_count <= 4'd0;
      end else if (soft_rst_req) begin
         // Soft request swallows any same-cycle timeout or lock loss.
         state <= RESET_PLL;
         cnt   <= '0;
      end else begin
         case (state)
            RESET_PLL: begin
               if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (lk_s) begin
                  state <= STABILIZE;
                  cnt   <= '0;
               end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                  state       <= RESET_PLL;
                  cnt         <= '0;
                  retry_count <= retry_inc;
                  if (retry_inc >= 4'(MAX_RETRIES)) fault <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABILIZE: begin
               // Any dropout restarts the window without counting as a retry.
               if (!lk_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                  state <= RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (!lk_s) begin
                  state       <= RESET_PLL;
                  cnt         <= '0;
                  retry_count <= retry_inc;
                  if (retry_inc >= 4'(MAX_RETRIES)) fault <= 1'b1;
               end
            end
            default: begin
               state <= RESET_PLL;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign pll_rst = (state == RESET_PLL);
   assign sys_rst = (state != RUN);
   assign ready   = (state == RUN);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters.
module tb_pll_reset_sequencer;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic       pll_rst, sys_rst, ready, fault;
   logic [3:0] retry_count;

   int checks = 0;
   int passed = 0;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (20),
      .STABLE_CYCLES  (8),
      .MAX_RETRIES    (2)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .soft_rst_req (soft_rst_req),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .fault        (fault),
      .retry_count  (retry_count)
   );

   always #10 refclk = ~refclk;

   // Counts consecutive negedge samples where pll_rst equals lvl.
   task automatic count_level(input logic lvl, output int n);
      n = 0;
      while (pll_rst === lvl && n < 200) begin
         n++;
         @(negedge refclk);
      end
   endtask

   // Counts cycles until sys_rst reaches lvl, sampling at negedge.
   task automatic cycles_to_sys_rst(input logic lvl, output int n);
      n = 0;
      do begin
         @(posedge refclk);
         @(negedge refclk);
         n++;
      end while (sys_rst !== lvl && n < 100);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      soft_rst_req = 1'b0;
      repeat (3) @(posedge refclk);
      #1 rst = 1'b0;
      @(negedge refclk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pll_locked = 1'b0;
      repeat (2) @(posedge refclk);
      @(negedge refclk);
      checks++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst got %b want 1", pll_rst); else passed++;
      checks++; if (sys_rst !== 1'b1) $display("FAIL reset_sys_rst got %b want 1", sys_rst); else passed++;
      checks++; if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready); else passed++;
      checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else passed++;
      checks++; if (retry_count !== 4'd0) $display("FAIL reset_retry got %0d want 0", retry_count); else passed++;
   endtask

   task automatic test_normal_lock();
      int n;
      pll_locked = 1'b0;
      do_reset();
      count_level(1'b1, n);
      checks++; if (n != 4) $display("FAIL normal_pll_rst_len got %0d want 4", n); else passed++;
      repeat (10) @(posedge refclk);
      #1 pll_locked = 1'b1;
      cycles_to_sys_rst(1'b0, n);
      checks++; if (n != 11) $display("FAIL normal_release_lat got %0d want 11", n); else passed++;
      checks++; if (ready !== 1'b1) $display("FAIL normal_ready got %b want 1", ready); else passed++;
      checks++; if (retry_count !== 4'd0) $display("FAIL normal_retry got %0d want 0", retry_count); else passed++;
   endtask

   task automatic test_stabilize_glitch();
      int n;
      pll_locked = 1'b0;
      do_reset();
      count_level(1'b1, n);
      repeat (10) @(posedge refclk);
      #1 pll_locked = 1'b1;
      repeat (5) @(posedge refclk);
      #1 pll_locked = 1'b0;
      repeat (2) @(posedge refclk);
      #1 pll_locked = 1'b1;
      @(negedge refclk);
      checks++; if (sys_rst !== 1'b1) $display("FAIL glitch_no_early_release got %b want 1", sys_rst); else passed++;
      @(posedge refclk);
      @(negedge refclk);
      n = 2;
      while (sys_rst === 1'b1 && n < 100) begin
         @(posedge refclk);
         @(negedge refclk);
         n++;
      end
      n--;
      // n counts posedges from the final rise to the release
      checks++; if (n != 11) $display("FAIL glitch_release_lat got %0d want 11", n); else passed++;
      checks++; if (retry_count !== 4'd0) $display("FAIL glitch_retry got %0d want 0", retry_count); else passed++;
   endtask

   task automatic test_lock_loss();
      int n;
      @(posedge refclk);
      #1 pll_locked = 1'b0;
      cycles_to_sys_rst(1'b1, n);
      checks++; if (n != 3) $display("FAIL loss_sys_rst_lat got %0d want 3", n); else passed++;
      count_level(1'b1, n);
      checks++; if (n != 4) $display("FAIL loss_pll_rst_len got %0d want 4", n); else passed++;
      checks++; if (retry_count !== 4'd1) $display("FAIL loss_retry got %0d want 1", retry_count); else passed++;
   endtask

   task automatic test_soft_race();
      int n;
      @(posedge refclk);
      #1 pll_locked = 1'b1;
      cycles_to_sys_rst(1'b0, n);
      checks++; if (ready !== 1'b1) $display("FAIL race_pre_ready got %b want 1", ready); else passed++;
      @(posedge refclk);
      #1 pll_locked = 1'b0;
      @(posedge refclk);
      @(posedge refclk);
      #1 soft_rst_req = 1'b1;
      @(posedge refclk);
      #1 soft_rst_req = 1'b0;
      @(negedge refclk);
      checks++; if (pll_rst !== 1'b1) $display("FAIL race_pll_rst got %b want 1", pll_rst); else passed++;
      checks++; if (retry_count !== 4'd1) $display("FAIL race_retry got %0d want 1", retry_count); else passed++;
      // Second request mid-pulse restarts the PLL reset pulse.
      @(posedge refclk);
      #1 soft_rst_req = 1'b1;
      @(negedge refclk);
      @(posedge refclk);
      #1 soft_rst_req = 1'b0;
      @(negedge refclk);
      count_level(1'b1, n);
      checks++; if (n != 4) $display("FAIL soft_extend_remaining got %0d want 4", n); else passed++;
      @(posedge refclk);
      #1 pll_locked = 1'b1;
      cycles_to_sys_rst(1'b0, n);
      checks++; if (n != 11) $display("FAIL race_relock_lat got %0d want 11", n); else passed++;
      checks++; if (retry_count !== 4'd1) $display("FAIL race_retry_after got %0d want 1", retry_count); else passed++;
   endtask

   task automatic test_timeout();
      int n;
      pll_locked = 1'b0;
      do_reset();
      count_level(1'b1, n);
      checks++; if (n != 4) $display("FAIL to_first_pulse got %0d want 4", n); else passed++;
      count_level(1'b0, n);
      checks++; if (n != 20) $display("FAIL to_wait_len got %0d want 20", n); else passed++;
      checks++; if (retry_count !== 4'd1) $display("FAIL to_retry1 got %0d want 1", retry_count); else passed++;
      checks++; if (fault !== 1'b0) $display("FAIL to_fault_early got %b want 0", fault); else passed++;
      count_level(1'b1, n);
      checks++; if (n != 4) $display("FAIL to_repulse got %0d want 4", n); else passed++;
      count_level(1'b0, n);
      checks++; if (retry_count !== 4'd2) $display("FAIL to_retry2 got %0d want 2", retry_count); else passed++;
      checks++; if (fault !== 1'b1) $display("FAIL to_fault got %b want 1", fault); else passed++;
      repeat (400) @(negedge refclk);
      checks++; if (retry_count !== 4'd15) $display("FAIL to_saturate got %0d want 15", retry_count); else passed++;
      checks++; if (fault !== 1'b1) $display("FAIL to_fault_sticky got %b want 1", fault); else passed++;
   endtask

   task automatic test_rst_mid_stabilize();
      int n;
      n = 0;
      while (pll_rst !== 1'b1 && n < 100) begin
         @(negedge refclk);
         n++;
      end
      count_level(1'b1, n);
      @(posedge refclk);
      #1 pll_locked = 1'b1;
      repeat (5) @(posedge refclk);
      #1 rst = 1'b1;
      @(posedge refclk);
      @(negedge refclk);
      checks++; if (pll_rst !== 1'b1) $display("FAIL rstmid_pll_rst got %b want 1", pll_rst); else passed++;
      checks++; if (sys_rst !== 1'b1) $display("FAIL rstmid_sys_rst got %b want 1", sys_rst); else passed++;
      checks++; if (ready !== 1'b0) $display("FAIL rstmid_ready got %b want 0", ready); else passed++;
      checks++; if (fault !== 1'b0) $display("FAIL rstmid_fault got %b want 0", fault); else passed++;
      checks++; if (retry_count !== 4'd0) $display("FAIL rstmid_retry got %0d want 0", retry_count); else passed++;
      #1 rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal_lock();
      test_stabilize_glitch();
      test_lock_loss();
      test_soft_race();
      test_timeout();
      test_rst_mid_stabilize();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
